// File: rtl/add16u_mon_pkg.sv
// Shared widths and state type for the adder error monitor.
package add16u_mon_pkg;

  localparam int unsigned W_DEF = 16;
  localparam int unsigned SUM_W = 49;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } mon_state_t;

endpackage

// File: rtl/add16u_abs_err.sv
// Exact W+1-bit sum of the operands and absolute difference from the observed result.
module add16u_abs_err #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W:0]   i_o,
  output logic [W:0]   o_err
);

  logic [W:0] w_exact;

  // Unsigned |observed - exact| without a signed intermediate.
  always_comb begin
    w_exact = {1'b0, i_a} + {1'b0, i_b};
    o_err   = '0;
    if (i_o >= w_exact) o_err = i_o - w_exact;
    else                o_err = w_exact - i_o;
  end

endmodule

// File: rtl/add16u_err_monitor.sv
// Measures the error of an adder under test over a run of n_samples samples.
module add16u_err_monitor
  import add16u_mon_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W:0]       in_o,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] sum_abs_err,
  output logic [W:0]       max_err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] sample_count
);

  mon_state_t       r_state;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_acc_cnt;
  logic             r_busy;
  logic             r_done;

  logic             r_s1_valid;
  logic [W-1:0]     r_s1_a;
  logic [W-1:0]     r_s1_b;
  logic [W:0]       r_s1_o;
  logic             r_s2_valid;
  logic [W:0]       r_s2_err;
  logic             r_s2_nz;

  logic [SUM_W-1:0] r_sum;
  logic [W:0]       r_max;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_smp_cnt;

  logic             w_ready;
  logic             w_accept;
  logic             w_start_ok;
  logic [W:0]       w_err;

  // Handshake and run-start qualification.
  always_comb begin
    w_ready    = (r_state == S_RUN) && (r_acc_cnt < r_n);
    w_accept   = in_valid && w_ready;
    w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  end

  add16u_abs_err #(.W(W)) u_abs_err (
    .i_a   (r_s1_a),
    .i_b   (r_s1_b),
    .i_o   (r_s1_o),
    .o_err (w_err)
  );

  // Run control FSM with registered busy/done.
  // A zero-length run has nothing to accept, so it goes straight to DRAIN.
  // DRAIN exits when stage 1 is empty: the last stage-2 sample commits on that same edge,
  // so done rises together with the final statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_n       <= '0;
      r_acc_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_n       <= n_samples;
            r_acc_cnt <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_state   <= (n_samples == '0) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_acc_cnt <= r_acc_cnt + 1'b1;
            if (r_acc_cnt + 1'b1 == r_n) r_state <= S_DRAIN;
          end else if (r_acc_cnt >= r_n) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!r_s1_valid) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Two-stage sample pipeline: capture, then error and nonzero flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid;
    end
    if (w_accept) begin
      r_s1_a <= in_a;
      r_s1_b <= in_b;
      r_s1_o <= in_o;
    end
    r_s2_err <= w_err;
    r_s2_nz  <= |w_err;
  end

  // Statistics accumulation; cleared on reset and on an accepted start.
  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      r_sum     <= '0;
      r_max     <= '0;
      r_err_cnt <= '0;
      r_smp_cnt <= '0;
    end else if (r_s2_valid) begin
      r_sum     <= r_sum + SUM_W'(r_s2_err);
      if (r_s2_err > r_max) r_max <= r_s2_err;
      r_err_cnt <= r_err_cnt + CNT_W'(r_s2_nz);
      r_smp_cnt <= r_smp_cnt + 1'b1;
    end
  end

  // Output mapping.
  always_comb begin
    in_ready     = w_ready;
    busy         = r_busy;
    done         = r_done;
    sum_abs_err  = r_sum;
    max_err      = r_max;
    err_count    = r_err_cnt;
    sample_count = r_smp_cnt;
  end

endmodule

// File: tb/tb_add16u_err_monitor.sv
// Directed bench for add16u_err_monitor with a run-level reference model.
module tb_add16u_err_monitor;

  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   n_samples;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [W:0]    in_o;
  logic          busy;
  logic          done;
  logic [48:0]   sum_abs_err;
  logic [W:0]    max_err;
  logic [31:0]   err_count;
  logic [31:0]   sample_count;

  add16u_err_monitor #(.W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .n_samples    (n_samples),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_o         (in_o),
    .busy         (busy),
    .done         (done),
    .sum_abs_err  (sum_abs_err),
    .max_err      (max_err),
    .err_count    (err_count),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the run at transaction level; each accepted sample
  // becomes visible in the statistics three cycles after the cycle it was accepted.
  typedef struct {
    int              due;
    longint unsigned err;
  } pend_t;

  pend_t           q[$];
  int              cyc = 0;
  bit              m_live = 0, clr_pend = 0, st_pend = 0;
  int unsigned     st_n = 0;
  bit              m_active = 0, m_done = 0;
  int              m_done_due = -1;
  int unsigned     m_cnt = 0, m_n = 0;
  longint unsigned m_sum = 0, m_max = 0, m_ec = 0, m_sc = 0;
  bit              ready_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : model_and_compare
    bit    exp_ready;
    pend_t p;
    int    exact;
    int    ov;
    if (clr_pend) begin
      q.delete();
      m_sum = 0; m_max = 0; m_ec = 0; m_sc = 0;
      m_active = 0; m_done = 0; m_done_due = -1;
      m_cnt = 0; m_n = 0; st_pend = 0; clr_pend = 0;
      m_live = 1;
    end
    if (st_pend) begin
      m_sum = 0; m_max = 0; m_ec = 0; m_sc = 0;
      m_done = 0; m_active = 1; m_cnt = 0; m_n = st_n;
      m_done_due = (st_n == 0) ? cyc + 1 : -1;
      st_pend = 0;
    end
    while (q.size() > 0 && q[0].due <= cyc) begin
      p = q.pop_front();
      m_sum += p.err;
      if (p.err > m_max) m_max = p.err;
      if (p.err != 0) m_ec++;
      m_sc++;
    end
    if (m_done_due == cyc) begin
      m_done = 1; m_active = 0; m_done_due = -1;
    end
    exp_ready = m_active && (m_cnt < m_n);
    if (in_ready === 1'b1) ready_seen = 1;
    if (m_live) begin
      check("in_ready",     64'(in_ready),     64'(exp_ready));
      check("busy",         64'(busy),         64'(m_active));
      check("done",         64'(done),         64'(m_done));
      check("sum_abs_err",  64'(sum_abs_err),  m_sum);
      check("max_err",      64'(max_err),      m_max);
      check("err_count",    64'(err_count),    m_ec);
      check("sample_count", 64'(sample_count), m_sc);
    end
    if (rst) begin
      clr_pend = 1;
    end else if (m_live) begin
      if (start && !m_active) begin
        st_pend = 1;
        st_n    = n_samples;
      end else if (in_valid && exp_ready) begin
        exact = int'(in_a) + int'(in_b);
        ov    = int'(in_o);
        p.due = cyc + 3;
        p.err = longint'((ov > exact) ? ov - exact : exact - ov);
        q.push_back(p);
        m_cnt++;
        if (m_cnt == m_n) m_done_due = cyc + 3;
      end
    end
  end

  task automatic tick(input int unsigned k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int unsigned n);
    start     = 1'b1;
    n_samples = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] o);
    int unsigned t;
    t        = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_o     = o;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) check("send_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int unsigned ncyc);
    ncyc = 0;
    do begin
      @(negedge clk);
      ncyc++;
    end while (done !== 1'b1 && ncyc < 50);
    if (done !== 1'b1) check("done_timeout", 64'(done), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag, input longint unsigned s, input longint unsigned m,
                             input longint unsigned e, input longint unsigned c);
    check({tag, "_sum"}, 64'(sum_abs_err), s);
    check({tag, "_max"}, 64'(max_err), m);
    check({tag, "_errcnt"}, 64'(err_count), e);
    check({tag, "_smpcnt"}, 64'(sample_count), c);
  endtask

  initial begin : global_timeout
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int unsigned nc;
    rst = 1'b1; start = 1'b0; n_samples = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_o = '0;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    check_stats("rst", 0, 0, 0, 0);
    @(posedge clk); #1;

    // Exact adder results, back to back.
    do_start(4);
    send(16'd1, 16'd2, 17'd3);
    send(16'hFFFF, 16'd1, 17'h10000);
    send(16'd0, 16'd0, 17'd0);
    send(16'd7, 16'd8, 17'd15);
    wait_done(nc);
    check("t1_done_latency", 64'(nc), 64'd3);
    check_stats("t1", 0, 0, 0, 4);

    // Errors of +4, -1, 0.
    do_start(3);
    send(16'd10, 16'd20, 17'd34);
    send(16'd5, 16'd5, 17'd9);
    send(16'd100, 16'd1, 17'd101);
    wait_done(nc);
    check_stats("t2", 5, 4, 2, 3);

    // Maximal error.
    do_start(1);
    send(16'd0, 16'd0, 17'h1FFFF);
    wait_done(nc);
    check_stats("t3", 64'h1FFFF, 64'h1FFFF, 1, 1);

    // Zero-length run.
    ready_seen = 0;
    do_start(0);
    wait_done(nc);
    check("t4_done_latency", 64'(nc), 64'd2);
    check("t4_ready_seen", 64'(ready_seen), 64'd0);
    check_stats("t4", 0, 0, 0, 0);

    // Gapped valid and an ignored second start.
    do_start(6);
    for (int i = 0; i < 6; i++) begin
      tick($urandom_range(0, 2));
      if (i == 2) do_start(2);
      send(16'(i * 3), 16'(i), 17'(i * 4 + (i % 2)));
    end
    wait_done(nc);
    check_stats("t5", 3, 1, 3, 6);

    // Reset one cycle after the second accept of a five-sample run.
    do_start(5);
    send(16'd2, 16'd2, 17'd5);
    send(16'd3, 16'd3, 17'd6);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check_stats("t6_rst", 0, 0, 0, 0);
    @(posedge clk); #1;
    tick(3);
    check_stats("t6_quiet", 0, 0, 0, 0);
    do_start(2);
    send(16'd1, 16'd1, 17'd2);
    send(16'd3, 16'd3, 17'd8);
    wait_done(nc);
    check_stats("t6_rerun", 2, 2, 1, 2);

    tick(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
